fabric_ci_ctrl: RTL and testbench

Sequencer that lets the CPU offload an operation to user logic in the FPGA fabric through the W_CPU_IO tile. It accepts one request (two operands plus a per-request fabric latency) and serialises the operands as 4-bit beats onto the tile's OPA/OPB inputs. It then waits the programmed latency, collects the result as 12-bit beats from the tile's RES0..RES2 outputs, and returns the assembled result on a valid/ready response channel. It sits in the CPU clock domain beside the tile, between the CPU's custom-instruction port and the fabric edge.

---
 rtl/fabric_ci_ctrl_if.sv | 27 ++
 rtl/fabric_ci_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fabric_ci_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_ci_ctrl_if.sv
// Custom-instruction request/response channel between the CPU port and fabric_ci_ctrl.
// master = CPU side, slave = controller side.
interface fabric_ci_ctrl_if #(
    parameter int unsigned OP_WIDTH  = 16,
    parameter int unsigned RES_WIDTH = 24,
    parameter int unsigned LAT_WIDTH = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [OP_WIDTH-1:0]  req_opa;
    logic [OP_WIDTH-1:0]  req_opb;
    logic [LAT_WIDTH-1:0] req_lat;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [RES_WIDTH-1:0] rsp_data;
    logic                 busy;

    modport master (
        output req_valid, req_opa, req_opb, req_lat, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_opa, req_opb, req_lat, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/fabric_ci_ctrl.sv
// Offload sequencer for the W_CPU_IO tile: streams operands out as 4-bit beats,
// waits the per-request fabric latency, gathers 12-bit result beats, returns the result.
module fabric_ci_ctrl #(
    parameter int unsigned OP_WIDTH  = 16,
    parameter int unsigned RES_WIDTH = 24,
    parameter int unsigned LAT_WIDTH = 4
) (
    input  logic            UserCLK,
    input  logic            resetn,
    fabric_ci_ctrl_if.slave ci,
    output logic [3:0]      fab_opa,
    output logic [3:0]      fab_opb,
    input  logic [11:0]     fab_res
);

    localparam int unsigned NB    = OP_WIDTH / 4;
    localparam int unsigned RB    = RES_WIDTH / 12;
    localparam int unsigned MAXB  = (NB > RB) ? NB : RB;
    localparam int unsigned CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [LAT_WIDTH-1:0] r_lat;
    logic [OP_WIDTH-1:0]  r_opa;
    logic [OP_WIDTH-1:0]  r_opb;
    logic [RES_WIDTH-1:0] r_res;
    logic [3:0]           r_fab_opa;
    logic [3:0]           r_fab_opb;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [LAT_WIDTH-1:0] w_lat_nxt;
    logic [OP_WIDTH-1:0]  w_opa_nxt;
    logic [OP_WIDTH-1:0]  w_opb_nxt;
    logic [RES_WIDTH-1:0] w_res_nxt;
    logic [3:0]           w_fab_opa_nxt;
    logic [3:0]           w_fab_opb_nxt;
    logic                 w_req_ready_nxt;
    logic                 w_rsp_valid_nxt;
    logic                 w_busy_nxt;

    // Next-state and next-output decode; fabric operand lines idle at zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_lat_nxt     = r_lat;
        w_opa_nxt     = r_opa;
        w_opb_nxt     = r_opb;
        w_res_nxt     = r_res;
        w_fab_opa_nxt = 4'h0;
        w_fab_opb_nxt = 4'h0;

        unique case (r_state)
            S_IDLE: begin
                if (ci.req_valid && r_req_ready) begin
                    // Beat 0 goes out on the acceptance edge; the shifters hold the rest.
                    w_state_nxt   = S_SEND;
                    w_cnt_nxt     = '0;
                    w_lat_nxt     = ci.req_lat;
                    w_opa_nxt     = OP_WIDTH'(ci.req_opa >> 4);
                    w_opb_nxt     = OP_WIDTH'(ci.req_opb >> 4);
                    w_fab_opa_nxt = ci.req_opa[3:0];
                    w_fab_opb_nxt = ci.req_opb[3:0];
                end
            end

            S_SEND: begin
                if (r_cnt == CNT_W'(NB - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_lat != '0) ? S_WAIT : S_RECV;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    w_fab_opa_nxt = r_opa[3:0];
                    w_fab_opb_nxt = r_opb[3:0];
                    w_opa_nxt     = OP_WIDTH'(r_opa >> 4);
                    w_opb_nxt     = OP_WIDTH'(r_opb >> 4);
                end
            end

            S_WAIT: begin
                if (r_lat <= LAT_WIDTH'(1)) begin
                    w_state_nxt = S_RECV;
                    w_lat_nxt   = '0;
                end else begin
                    w_lat_nxt = r_lat - LAT_WIDTH'(1);
                end
            end

            S_RECV: begin
                // Shift in from the top so beat 0 ends up in the LS slot after RB beats.
                w_res_nxt = RES_WIDTH'({fab_res, r_res} >> 12);
                if (r_cnt == CNT_W'(RB - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_RESP: begin
                if (ci.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset drops any request in flight.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_lat       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_res       <= '0;
            r_fab_opa   <= 4'h0;
            r_fab_opb   <= 4'h0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lat       <= w_lat_nxt;
            r_opa       <= w_opa_nxt;
            r_opb       <= w_opb_nxt;
            r_res       <= w_res_nxt;
            r_fab_opa   <= w_fab_opa_nxt;
            r_fab_opb   <= w_fab_opb_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign ci.req_ready = r_req_ready;
    assign ci.rsp_valid = r_rsp_valid;
    assign ci.rsp_data  = r_res;
    assign ci.busy      = r_busy;
    assign fab_opa      = r_fab_opa;
    assign fab_opb      = r_fab_opb;

    // Design invariants.
    a_rsp_stable : assert property (@(posedge UserCLK) disable iff (!resetn)
        (r_rsp_valid && !ci.rsp_ready) |=> (r_rsp_valid && $stable(r_res)));

    a_fab_idle_zero : assert property (@(posedge UserCLK) disable iff (!resetn)
        (r_state != S_SEND) |-> (r_fab_opa == 4'h0 && r_fab_opb == 4'h0));

    a_busy_decode : assert property (@(posedge UserCLK) disable iff (!resetn)
        (r_busy == (r_state != S_IDLE)) && (r_req_ready == (r_state == S_IDLE)));

endmodule

// File: tb/tb_fabric_ci_ctrl.sv
// Scoreboard bench for fabric_ci_ctrl: directed requests push expected responses,
// an independent monitor pops and checks them when the response channel fires.
module tb_fabric_ci_ctrl;

    localparam int unsigned OPW  = 16;
    localparam int unsigned RESW = 24;
    localparam int unsigned LATW = 4;
    localparam int NB = 4;
    localparam int RB = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fabric_ci_ctrl_if #(.OP_WIDTH(OPW), .RES_WIDTH(RESW), .LAT_WIDTH(LATW)) ci ();
    logic [3:0]  fab_opa, fab_opb;
    logic [11:0] fab_res;

    fabric_ci_ctrl #(.OP_WIDTH(OPW), .RES_WIDTH(RESW), .LAT_WIDTH(LATW)) dut (
        .UserCLK (clk),
        .resetn  (resetn),
        .ci      (ci),
        .fab_opa (fab_opa),
        .fab_opb (fab_opb),
        .fab_res (fab_res)
    );

    // Minimal configuration: one beat each way.
    fabric_ci_ctrl_if #(.OP_WIDTH(4), .RES_WIDTH(12), .LAT_WIDTH(4)) sm_ci ();
    logic [3:0]  sm_fab_opa, sm_fab_opb;
    logic [11:0] sm_fab_res;

    fabric_ci_ctrl #(.OP_WIDTH(4), .RES_WIDTH(12), .LAT_WIDTH(4)) dut_sm (
        .UserCLK (clk),
        .resetn  (resetn),
        .ci      (sm_ci),
        .fab_opa (sm_fab_opa),
        .fab_opb (sm_fab_opb),
        .fab_res (sm_fab_res)
    );

    typedef struct {
        logic [23:0] data;
        int          vcyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   prev_valid = 1'b0;
    int   t, t1, t2, rv_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hold the request until the DUT takes it; t is the cycle ending at the acceptance edge.
    task automatic accept(input logic [15:0] opa, input logic [15:0] opb,
                          input logic [3:0] lat, output int tacc);
        bit rr;
        bit ok;
        ok   = 1'b0;
        tacc = -1;
        ci.req_valid = 1'b1;
        ci.req_opa   = opa;
        ci.req_opb   = opb;
        ci.req_lat   = lat;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            rr = (ci.req_ready === 1'b1);
            @(posedge clk);
            #1;
            if (rr) begin
                ok   = 1'b1;
                tacc = cyc - 1;
            end
        end
        ci.req_valid = 1'b0;
        ci.req_opa   = ~opa;
        ci.req_opb   = ~opb;
        ci.req_lat   = ~lat;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: request not accepted within 100 cycles");
        end
    endtask

    task automatic issue(input logic [15:0] opa, input logic [15:0] opb,
                         input logic [3:0] lat, input logic [23:0] res, output int tacc);
        exp_t e;
        accept(opa, opb, lat, tacc);
        e.data = res;
        e.vcyc = tacc + NB + int'(lat) + RB + 1;
        sb_q.push_back(e);
    endtask

    // Fabric model: checks operand beats, drives garbage until the result window opens.
    task automatic run_fab(input logic [15:0] opa, input logic [15:0] opb,
                           input logic [3:0] lat, input logic [23:0] res, input int tacc);
        int k;
        int j;
        for (int c = tacc + 1; c <= tacc + NB + int'(lat) + RB; c++) begin
            k = c - (tacc + 1);
            j = c - (tacc + NB + int'(lat) + 1);
            fab_res = (j >= 0) ? 12'(res >> (12 * j)) : 12'hFFF;
            @(negedge clk);
            chk("fab_opa", 32'(fab_opa), (k < NB) ? 32'(4'(opa >> (4 * k))) : 32'd0);
            chk("fab_opb", 32'(fab_opb), (k < NB) ? 32'(4'(opb >> (4 * k))) : 32'd0);
            @(posedge clk);
            #1;
        end
        fab_res = 12'hFFF;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(ci.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(ci.rsp_valid), 32'd0);
        chk({tag, "_busy"},      32'(ci.busy),      32'd0);
        chk({tag, "_rsp_data"},  32'(ci.rsp_data),  32'd0);
        chk({tag, "_fab_opa"},   32'(fab_opa),      32'd0);
        chk({tag, "_fab_opb"},   32'(fab_opb),      32'd0);
    endtask

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn !== 1'b1) begin
                prev_valid = 1'b0;
            end else begin
                if (ci.rsp_valid === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        if (!prev_valid) begin
                            checks++;
                            failures++;
                            $display("FAIL rsp_unexpected: data=0x%0h at cycle %0d, nothing expected",
                                     ci.rsp_data, cyc);
                        end
                    end else begin
                        if (!prev_valid)
                            chk("rsp_valid_cycle", 32'(cyc), 32'(sb_q[0].vcyc));
                        chk("rsp_data", 32'(ci.rsp_data), 32'(sb_q[0].data));
                        if (ci.rsp_ready === 1'b1) void'(sb_q.pop_front());
                    end
                end
                prev_valid = (ci.rsp_valid === 1'b1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Dirty reset: inputs unknown, reset asserted before any clock edge.
        resetn          = 1'b1;
        ci.req_valid    = 1'bx;
        ci.req_opa      = 'x;
        ci.req_opb      = 'x;
        ci.req_lat      = 'x;
        ci.rsp_ready    = 1'bx;
        fab_res         = 'x;
        sm_ci.req_valid = 1'bx;
        sm_ci.req_opa   = 'x;
        sm_ci.req_opb   = 'x;
        sm_ci.req_lat   = 'x;
        sm_ci.rsp_ready = 1'bx;
        sm_fab_res      = 'x;
        #2 resetn = 1'b0;
        #1 chk_reset_outputs("rst");

        ci.req_valid    = 1'b0;
        ci.req_opa      = '0;
        ci.req_opb      = '0;
        ci.req_lat      = '0;
        ci.rsp_ready    = 1'b1;
        fab_res         = 12'hFFF;
        sm_ci.req_valid = 1'b0;
        sm_ci.req_opa   = '0;
        sm_ci.req_opb   = '0;
        sm_ci.req_lat   = '0;
        sm_ci.rsp_ready = 1'b1;
        sm_fab_res      = 12'hFFF;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(ci.req_ready), 32'd1);
        chk("post_rst_busy",      32'(ci.busy),      32'd0);
        @(posedge clk);
        #1;

        // Basic transfer, lat=0.
        issue(16'h1234, 16'hABCD, 4'd0, 24'h654321, t);
        run_fab(16'h1234, 16'hABCD, 4'd0, 24'h654321, t);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rsp_data_hold", 32'(ci.rsp_data), 32'h654321);
        chk("idle_rsp_valid", 32'(ci.rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Maximum latency with garbage on fab_res during WAIT.
        issue(16'hF00D, 16'h0123, 4'd15, 24'h0BB0AA, t);
        run_fab(16'hF00D, 16'h0123, 4'd15, 24'h0BB0AA, t);
        @(posedge clk);
        #1;

        // Back-pressure: response held 10 cycles while a second request waits.
        ci.rsp_ready = 1'b0;
        issue(16'h5A5A, 16'h0F0F, 4'd1, 24'hC0FFEE, t);
        run_fab(16'h5A5A, 16'h0F0F, 4'd1, 24'hC0FFEE, t);
        rv_cyc = cyc;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_rsp_valid", 32'(ci.rsp_valid), 32'd1);
                    chk("bp_req_ready", 32'(ci.req_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                ci.rsp_ready = 1'b1;
            end
            begin
                issue(16'h1111, 16'h2222, 4'd0, 24'h123456, t2);
            end
        join
        chk("bp_accept_cycle", 32'(t2), 32'(rv_cyc + 11));
        run_fab(16'h1111, 16'h2222, 4'd0, 24'h123456, t2);
        @(posedge clk);
        #1;

        // Reset during WAIT: no response may ever appear for this request.
        fab_res = 12'hEEE;
        accept(16'h9999, 16'h8888, 4'd10, t);
        repeat (NB + 2) @(posedge clk);
        #3 resetn = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("midrst_release_busy", 32'(ci.busy), 32'd0);
        @(posedge clk);
        #1;
        issue(16'h0001, 16'h0002, 4'd0, 24'h000777, t);
        run_fab(16'h0001, 16'h0002, 4'd0, 24'h000777, t);
        @(posedge clk);
        #1;

        // Back-to-back with rsp_ready high: spacing NB+L+RB+2 = 10 for L=2.
        issue(16'hCAFE, 16'hBEEF, 4'd2, 24'h111222, t1);
        run_fab(16'hCAFE, 16'hBEEF, 4'd2, 24'h111222, t1);
        issue(16'h4321, 16'h8765, 4'd2, 24'h333444, t2);
        chk("b2b_spacing", 32'(t2 - t1), 32'd10);
        run_fab(16'h4321, 16'h8765, 4'd2, 24'h333444, t2);
        repeat (2) @(posedge clk);
        #1;

        // Single-beat instance: rsp_valid three cycles after acceptance with lat=0.
        sm_ci.req_valid = 1'b1;
        sm_ci.req_opa   = 4'h7;
        sm_ci.req_opb   = 4'h9;
        sm_ci.req_lat   = 4'h0;
        @(negedge clk);
        chk("sm_req_ready", 32'(sm_ci.req_ready), 32'd1);
        @(posedge clk);
        #1;
        t = cyc - 1;
        sm_ci.req_valid = 1'b0;
        sm_ci.req_opa   = 4'h0;
        sm_ci.req_opb   = 4'h0;
        @(negedge clk);
        chk("sm_fab_opa", 32'(sm_fab_opa), 32'h7);
        chk("sm_fab_opb", 32'(sm_fab_opb), 32'h9);
        @(posedge clk);
        #1 sm_fab_res = 12'hABC;
        @(negedge clk);
        chk("sm_recv_fab_opa", 32'(sm_fab_opa), 32'h0);
        chk("sm_recv_rsp_valid", 32'(sm_ci.rsp_valid), 32'd0);
        @(posedge clk);
        #1 sm_fab_res = 12'hFFF;
        @(negedge clk);
        chk("sm_rsp_valid", 32'(sm_ci.rsp_valid), 32'd1);
        chk("sm_rsp_cycle", 32'(cyc), 32'(t + 3));
        chk("sm_rsp_data",  32'(sm_ci.rsp_data), 32'hABC);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sm_idle_rsp_valid", 32'(sm_ci.rsp_valid), 32'd0);
        chk("sm_idle_req_ready", 32'(sm_ci.req_ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
